aes_encrypt_core: RTL and testbench
===================================

# aes_encrypt_core

Iterative AES-128 encryption datapath that sits directly downstream of `KeyExpansion`. It takes a 128-bit plaintext block and the flat 1408-bit schedule of eleven round keys, and applies one AES round per clock. It returns the 128-bit ciphertext with a start/done handshake. S-box lookups reuse the existing 8-bit `SubWord` module, with 16 instances, one per state byte.

## Interface
- `ROUNDS`, default 10: number of cipher rounds. Only the value 10 (AES-128) is supported; any other value is a configuration error.
- `clk`, input, 1: the single clock for the block.
- `reset`, input, 1: reset is synchronous and active-high. It clears all state on the rising edge of `clk`.
- `start`, input, 1: request to begin encrypting `plaintext`. It is sampled only while `busy` is 0.
- `plaintext`, input, [0:127]: input block, big-endian, in FIPS-197 byte order. It is sampled on the edge that accepts `start`.
- `round_keys`, input, [0:1407]:
  - Round key r occupies bits [128r : 128r+127], where r = 0..10.
  - The driver is `KeyExpansion.keys_output`.
  - This input is not latched. It must be held stable from the `start` edge through the `done` edge.
- `busy`, output, 1: high while rounds are in progress.
- `done`, output, 1: single-cycle pulse that marks `ciphertext` as valid.
- `ciphertext`, output, [0:127]: result register. It holds its value until the next completion or reset.

## Operation
- State mapping:
  - State byte s[row][col] = bits [32·col + 8·row : 32·col + 8·row + 7], which is column-major as in FIPS-197.
  - Byte 0 is bits [0:7].
- Registers:
  - `state` [0:127].
  - `round_cnt`, 4 bits, values 1..10.
  - The `busy`, `done` and `ciphertext` outputs.
- FSM states:
  - IDLE:
    - `busy` = 0.
    - When `start` = 1: set `state` <= `plaintext` ^ rk0 and `round_cnt` <= 1, then go to ROUND.
  - ROUND:
    - Compute `state` <= MixColumns(ShiftRows(SubBytes(state))) ^ rk[round_cnt].
    - Increment `round_cnt`.
    - When `round_cnt` = 9 is being applied, go to FINAL next.
  - FINAL:
    - Compute the result = ShiftRows(SubBytes(state)) ^ rk10, with no MixColumns.
    - Load the result into `ciphertext`.
    - Set `done` <= 1 and `busy` <= 0, then go to IDLE.
- ShiftRows: row r rotates left by r bytes, for r = 0..3.
- MixColumns:
  - Standard GF(2^8) matrix [2 3 1 1; 1 2 3 1; 1 1 2 3; 3 1 1 2].
  - xtime(b) = (b << 1) ^ (b[7] ? 8'h1B : 0), where b[7] is the MSB.
  - All arithmetic is 8-bit XOR; there is no carry.
- Round-key selection: a mux on `round_cnt` picks the 128-bit slice of `round_keys`.
- `start` while `busy` = 1: ignored. The in-flight operation is unaffected and there is no queueing.
- `start` in the same cycle that `done` = 1: accepted, because `busy` is already 0. `done` drops on the next edge.
- `ciphertext` is not cleared when a new `start` is accepted. It changes only when the FINAL state writes it.
- Reset (including mid-operation), on the next edge:
  - FSM goes to IDLE.
  - `busy`, `done` and `round_cnt` go to 0.
  - `ciphertext` and `state` go to 128'h0.
  - No `done` pulse is emitted for the aborted block.

## Timing
- Reset values:
  - `busy` = 0.
  - `done` = 0.
  - `ciphertext` = 0.
- Latency: edge E0 samples `start`.
  - Edges E1..E9 apply rounds 1..9.
  - Edge E10 applies round 10 and asserts `done`.
  - `done` is therefore visible for exactly one cycle, between E10 and E11.
  - Latency is 11 edges from the `start` edge to `done` visible.
- `busy`:
  - Rises after E0.
  - Falls after E10, in the same edge that `done` rises.
- Throughput: one block per 11 cycles, including when `start` is issued back-to-back on the `done` cycle.
- All outputs are registered. There is no combinational path from any input to any output.
- The critical path is S-box → ShiftRows → MixColumns → XOR with the round key, all within one cycle.

## Test plan
- FIPS-197 App. B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c, expanded by `KeyExpansion`.
  - Plaintext 3243f6a8885a308d313198a2e0370734.
  - Required: ciphertext 3925841d02dc09fbdc118597196a0b32, with `done` exactly 11 edges after `start`.
- FIPS-197 App. C.1:
  - Key 000102030405060708090a0b0c0d0e0f.
  - Plaintext 00112233445566778899aabbccddeeff.
  - Required: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a, and `done` is high for exactly 1 cycle.
- `start` held high for the whole run with new plaintext on every cycle:
  - Only the plaintext sampled at E0 is encrypted.
  - Blocks complete every 11 cycles.
  - Each ciphertext matches the plaintext sampled on its own accepting edge.
- Back-to-back operation: App. B is accepted, then `start` with App. C.1 is asserted on App. B's `done` cycle. Required:
  - Both ciphertexts are correct.
  - The second `done` arrives 11 cycles after the first.
  - `busy` stays low for 0 extra cycles.
- Reset mid-operation: `reset` = 1 after round 5. Required:
  - `busy` = 0, `done` = 0 and `ciphertext` = 0 on the next edge.
  - No `done` pulse follows.
  - A subsequent App. B run still produces 3925841d02dc09fbdc118597196a0b32.

Source files
------------

// File: rtl/aes_encrypt_core.sv
// AES-128 iterative encryption core: one cipher round per clock, start/done handshake.
// Round keys come from KeyExpansion.keys_output and must stay stable for the whole block.

// 8-bit AES S-box: multiplicative inverse in GF(2^8) followed by the affine transform.
module SubWord (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // a^254 == a^-1 for a != 0, and maps 0 to 0 as the S-box requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a3, a7, a15, a31, a63, a127;
        a3   = gf_mul(gf_mul(a, a), a);
        a7   = gf_mul(gf_mul(a3, a3), a);
        a15  = gf_mul(gf_mul(a7, a7), a);
        a31  = gf_mul(gf_mul(a15, a15), a);
        a63  = gf_mul(gf_mul(a31, a31), a);
        a127 = gf_mul(gf_mul(a63, a63), a);
        return gf_mul(a127, a127);
    endfunction

    logic [7:0] inv;

    // Inverse then affine transform
    always_comb begin
        inv      = gf_inv(in_byte);
        out_byte = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

module aes_encrypt_core #(
    parameter int unsigned ROUNDS = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [0:127]  plaintext,
    input  logic [0:1407] round_keys,
    output logic          busy,
    output logic          done,
    output logic [0:127]  ciphertext
);

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    if (ROUNDS != 10) begin : g_rounds_check
        $fatal(1, "aes_encrypt_core: only ROUNDS=10 (AES-128) is supported");
    end

    fsm_t         fsm_q;
    logic [0:127] state_q;
    logic [3:0]   round_cnt_q;
    logic         busy_q;
    logic         done_q;
    logic [0:127] ciphertext_q;

    logic [0:127] sub_d;
    logic [0:127] shift_d;
    logic [0:127] mix_d;
    logic [0:127] rk_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        SubWord u_sbox (
            .in_byte  (state_q[8*i +: 8]),
            .out_byte (sub_d[8*i +: 8])
        );
    end

    // ShiftRows: byte s[r][c] takes s[r][(c+r)%4] (column-major byte layout)
    always_comb begin
        shift_d = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                shift_d[32*c + 8*r +: 8] = sub_d[32*((c + r) % 4) + 8*r +: 8];
            end
        end
    end

    // MixColumns over each 32-bit column
    always_comb begin
        logic [7:0] a0, a1, a2, a3;
        mix_d = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            a0 = shift_d[32*c      +: 8];
            a1 = shift_d[32*c + 8  +: 8];
            a2 = shift_d[32*c + 16 +: 8];
            a3 = shift_d[32*c + 24 +: 8];
            mix_d[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            mix_d[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            mix_d[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            mix_d[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
    end

    // Round-key mux: select the 128-bit slice for the current round
    always_comb begin
        rk_d = '0;
        for (int unsigned r = 0; r <= 10; r++) begin
            if (round_cnt_q == 4'(r)) rk_d = round_keys[128*r +: 128];
        end
    end

    // Control FSM and all state/output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= IDLE;
            state_q      <= '0;
            round_cnt_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ciphertext_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= plaintext ^ round_keys[0:127];
                        round_cnt_q <= 4'd1;
                        busy_q      <= 1'b1;
                        fsm_q       <= ROUND;
                    end
                end
                ROUND: begin
                    state_q     <= mix_d ^ rk_d;
                    round_cnt_q <= round_cnt_q + 4'd1;
                    if (round_cnt_q == 4'd9) fsm_q <= FINAL;
                end
                FINAL: begin
                    ciphertext_q <= shift_d ^ rk_d;
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    fsm_q        <= IDLE;
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ciphertext = ciphertext_q;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Self-checking bench for aes_encrypt_core with a byte-matrix AES reference model.
module tb_aes_encrypt_core;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [0:127]  plaintext;
    logic [0:1407] round_keys;
    logic          busy;
    logic          done;
    logic [0:127]  ciphertext;

    int total = 0;
    int bad   = 0;

    logic [7:0] sbox_t [256];

    aes_encrypt_core #(.ROUNDS(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .round_keys (round_keys),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    // S-box table generated by walking the field with generator 3 and its inverse
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
            sbox_t[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        while (bb != 8'h00) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [1407:0] ref_expand(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1407:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sbox_t[tmp[31:24]], sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]]}
                      ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        res = '0;
        for (int i = 0; i < 44; i++) res[1407 - 32*i -: 32] = w[i];
        return res;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [1407:0] rks);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [127:0] k;
        logic [127:0] res;
        int           base [4] = '{2, 3, 1, 1};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = pt[127 - 8*(4*c + r) -: 8];
        for (int rd = 0; rd <= 10; rd++) begin
            if (rd > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[r][c] = sbox_t[s[r][(c + r) % 4]];
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++) begin
                        if (rd < 10) begin
                            s[r][c] = 8'h00;
                            for (int i = 0; i < 4; i++)
                                s[r][c] = s[r][c] ^ gmul(8'(base[(i - r + 4) % 4]), t[i][c]);
                        end else begin
                            s[r][c] = t[r][c];
                        end
                    end
            end
            k = rks[1407 - 128*rd -: 128];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = s[r][c] ^ k[127 - 8*(4*c + r) -: 8];
        end
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[r][c];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic launch(input logic [127:0] pt);
        plaintext = pt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges from the accepting edge (inclusive) until done is seen, bounded
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (done !== 1'b1 && cyc < 30) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start      = 1'b0;
        plaintext  = '0;
        round_keys = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL rst_ct: got %h want 0", ciphertext); end
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_fips_b();
        int cyc;
        round_keys = ref_expand(KEY_B);
        launch(PT_B);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b_busy: got %b want 1", busy); end
        wait_done(cyc);
        total++; if (done !== 1'b1 || cyc != 11) begin bad++; $display("FAIL b_latency: got %0d done=%b want 11", cyc, done); end
        total++; if (ciphertext !== CT_B) begin bad++; $display("FAIL b_ct: got %h want %h", ciphertext, CT_B); end
        total++; if (ciphertext !== ref_encrypt(PT_B, round_keys)) begin bad++; $display("FAIL b_model: got %h want %h", ciphertext, ref_encrypt(PT_B, round_keys)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL b_busy_done: got %b want 0", busy); end
        @(posedge clk);
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL b_pulse: got %b want 0", done); end
    endtask

    task automatic test_fips_c1();
        int cyc;
        int high;
        round_keys = ref_expand(KEY_C1);
        launch(PT_C1);
        wait_done(cyc);
        total++; if (done !== 1'b1 || cyc != 11) begin bad++; $display("FAIL c1_latency: got %0d done=%b want 11", cyc, done); end
        total++; if (ciphertext !== CT_C1) begin bad++; $display("FAIL c1_ct: got %h want %h", ciphertext, CT_C1); end
        high = 1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) high++;
        end
        total++; if (high != 1) begin bad++; $display("FAIL c1_pulse_width: got %0d want 1", high); end
        total++; if (ciphertext !== CT_C1) begin bad++; $display("FAIL c1_hold: got %h want %h", ciphertext, CT_C1); end
    endtask

    task automatic test_random();
        int cyc;
        logic [127:0] pt;
        logic [127:0] exp;
        repeat (5) begin
            round_keys = ref_expand(rand128());
            pt  = rand128();
            exp = ref_encrypt(pt, round_keys);
            launch(pt);
            wait_done(cyc);
            total++; if (done !== 1'b1 || cyc != 11) begin bad++; $display("FAIL rnd_latency: got %0d done=%b want 11", cyc, done); end
            total++; if (ciphertext !== exp) begin bad++; $display("FAIL rnd_ct: got %h want %h", ciphertext, exp); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_start_held();
        logic [127:0] pts [34];
        logic [127:0] exp;
        round_keys = ref_expand(rand128());
        pts[0]    = rand128();
        plaintext = pts[0];
        start     = 1'b1;
        for (int k = 0; k < 33; k++) begin
            @(posedge clk);
            #1;
            if (k % 11 == 10) begin
                exp = ref_encrypt(pts[k - 10], round_keys);
                total++; if (done !== 1'b1) begin bad++; $display("FAIL held_done@%0d: got %b want 1", k, done); end
                total++; if (ciphertext !== exp) begin bad++; $display("FAIL held_ct@%0d: got %h want %h", k, ciphertext, exp); end
                total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_busy@%0d: got %b want 0", k, busy); end
            end else begin
                total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL held_run@%0d: got done=%b busy=%b want done=0 busy=1", k, done, busy); end
            end
            pts[k + 1] = rand128();
            plaintext  = pts[k + 1];
            if (k == 32) start = 1'b0;
        end
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL held_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int cyc1;
        int cyc2;
        round_keys = ref_expand(KEY_B);
        launch(PT_B);
        wait_done(cyc1);
        total++; if (done !== 1'b1 || cyc1 != 11) begin bad++; $display("FAIL b2b_first_latency: got %0d want 11", cyc1); end
        total++; if (ciphertext !== CT_B) begin bad++; $display("FAIL b2b_first_ct: got %h want %h", ciphertext, CT_B); end
        round_keys = ref_expand(KEY_C1);
        launch(PT_C1);
        total++; if (done !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got done=%b busy=%b want done=0 busy=1", done, busy); end
        total++; if (ciphertext !== CT_B) begin bad++; $display("FAIL b2b_ct_hold: got %h want %h", ciphertext, CT_B); end
        wait_done(cyc2);
        total++; if (done !== 1'b1 || cyc2 != 11) begin bad++; $display("FAIL b2b_second_gap: got %0d want 11", cyc2); end
        total++; if (ciphertext !== CT_C1) begin bad++; $display("FAIL b2b_second_ct: got %h want %h", ciphertext, CT_C1); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int seen;
        int cyc;
        round_keys = ref_expand(KEY_B);
        launch(PT_B);
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mid_done: got %b want 0", done); end
        total++; if (ciphertext !== 128'h0) begin bad++; $display("FAIL mid_ct: got %h want 0", ciphertext); end
        seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL mid_no_done: got %0d active cycles want 0", seen); end
        launch(PT_B);
        wait_done(cyc);
        total++; if (done !== 1'b1 || cyc != 11) begin bad++; $display("FAIL mid_rerun_latency: got %0d want 11", cyc); end
        total++; if (ciphertext !== CT_B) begin bad++; $display("FAIL mid_rerun_ct: got %h want %h", ciphertext, CT_B); end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_random();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
